// File: rtl/vpu_d2h_resp_ctrl_pkg.sv
// VPU shared types for the H2D instruction and D2H response paths.
// SRAM addressing helpers split a byte address into {bank, word}.
package vpu_d2h_resp_ctrl_pkg;

  localparam int REQ_FIFO_DEPTH      = 16;
  localparam int REQ_FIFO_DEPTH_LG2  = 4;
  localparam int SRAM_BANK_CNT_LG2   = 2;
  localparam int SRAM_BANK_DEPTH_LG2 = 10;
  localparam int SRAM_LINE_LG2       = 6;
  localparam int SRAM_ADDR_W         =
    SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2;
  localparam int RESP_SEQ_WIDTH      = REQ_FIFO_DEPTH_LG2;

  typedef enum logic [1:0] {
    RESP_OK            = 2'b00,
    RESP_ADDR_MISMATCH = 2'b01
  } vpu_d2h_resp_status_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] dst0;
    logic [31:0] src0;
    logic [31:0] src1;
    logic [31:0] src2;
  } vpu_h2d_req_instr_t;

  typedef struct packed {
    logic [7:0]                opcode;
    logic [31:0]               dst0;
    logic [RESP_SEQ_WIDTH-1:0] seq;
    vpu_d2h_resp_status_t      status;
  } vpu_d2h_resp_t;

  function automatic logic [SRAM_BANK_CNT_LG2-1:0] get_bank_id(
    input logic [31:0] addr
  );
    return addr[SRAM_LINE_LG2+SRAM_BANK_DEPTH_LG2 +: SRAM_BANK_CNT_LG2];
  endfunction

  function automatic logic [SRAM_BANK_DEPTH_LG2-1:0] get_waddr(
    input logic [31:0] addr
  );
    return addr[SRAM_LINE_LG2 +: SRAM_BANK_DEPTH_LG2];
  endfunction

endpackage

// File: rtl/vpu_resp_track_buf.sv
// In-order tracking store with write, completion and read pointers.
// Extra pointer MSB separates full from empty.
module vpu_resp_track_buf
  import vpu_d2h_resp_ctrl_pkg::*;
#(
  parameter int TRK_DEPTH     = REQ_FIFO_DEPTH,
  parameter int TRK_DEPTH_LG2 = REQ_FIFO_DEPTH_LG2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  vpu_d2h_resp_t            push_data,
  input  logic                     cmp,
  input  vpu_d2h_resp_status_t     cmp_status,
  output logic                     cmp_avail,
  output logic [31:0]              cmp_dst0,
  input  logic                     pop,
  output logic                     pop_avail,
  output vpu_d2h_resp_t            pop_data,
  output logic                     full,
  output logic [TRK_DEPTH_LG2:0]   cnt
);

  localparam logic [TRK_DEPTH_LG2:0] DEPTH_W =
    (TRK_DEPTH_LG2+1)'(TRK_DEPTH);

  vpu_d2h_resp_t            mem [TRK_DEPTH];
  logic [TRK_DEPTH-1:0]     done_q;
  logic [TRK_DEPTH_LG2:0]   wr_ptr;
  logic [TRK_DEPTH_LG2:0]   cmp_ptr;
  logic [TRK_DEPTH_LG2:0]   rd_ptr;
  logic [TRK_DEPTH_LG2-1:0] wr_idx;
  logic [TRK_DEPTH_LG2-1:0] cmp_idx;
  logic [TRK_DEPTH_LG2-1:0] rd_idx;

  assign wr_idx  = wr_ptr[TRK_DEPTH_LG2-1:0];
  assign cmp_idx = cmp_ptr[TRK_DEPTH_LG2-1:0];
  assign rd_idx  = rd_ptr[TRK_DEPTH_LG2-1:0];

  assign cnt       = wr_ptr - rd_ptr;
  assign full      = (cnt == DEPTH_W);
  assign cmp_avail = (cmp_ptr != wr_ptr);
  assign cmp_dst0  = mem[cmp_idx].dst0;
  assign pop_avail = (rd_ptr != cmp_ptr) && done_q[rd_idx];
  assign pop_data  = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      cmp_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      if (push) wr_ptr  <= wr_ptr + 1'b1;
      if (cmp)  cmp_ptr <= cmp_ptr + 1'b1;
      if (pop)  rd_ptr  <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
    end else begin
      if (push) done_q[wr_idx]  <= 1'b0;
      if (cmp)  done_q[cmp_idx] <= 1'b1;
    end
  end

  // Payload needs no reset; done_q and pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_data;
    if (cmp)  mem[cmp_idx].status <= cmp_status;
  end

endmodule

// File: rtl/vpu_d2h_resp_ctrl.sv
// D2H completion responder: tracks accepted H2D instructions and
// returns one in-order response per instruction after write-back.
module vpu_d2h_resp_ctrl
  import vpu_d2h_resp_ctrl_pkg::*;
#(
  parameter int TRK_DEPTH     = REQ_FIFO_DEPTH,
  parameter int TRK_DEPTH_LG2 = REQ_FIFO_DEPTH_LG2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_accept_i,
  input  vpu_h2d_req_instr_t       instr_i,
  input  logic                     wb_done_i,
  input  logic [SRAM_ADDR_W-1:0]   wb_addr_i,
  output logic                     d2h_resp_valid_o,
  input  logic                     d2h_resp_ready_i,
  output vpu_d2h_resp_t            d2h_resp_o,
  output logic                     trk_full_o,
  output logic [TRK_DEPTH_LG2:0]   trk_cnt_o,
  output logic                     idle_o,
  output logic                     err_overflow_o,
  output logic                     err_underflow_o
);

  logic                      push;
  logic                      cmp;
  logic                      pop;
  logic                      cmp_avail;
  logic                      pop_avail;
  logic [31:0]               cmp_dst0;
  logic [SRAM_ADDR_W-1:0]    exp_addr;
  logic [RESP_SEQ_WIDTH-1:0] seq_cnt;
  vpu_d2h_resp_t             push_data;
  vpu_d2h_resp_t             pop_data;
  vpu_d2h_resp_status_t      cmp_status;
  logic                      unused_instr;

  assign unused_instr = ^{instr_i.src0, instr_i.src1, instr_i.src2};

  assign push = instr_accept_i && !trk_full_o;
  assign cmp  = wb_done_i && cmp_avail;
  assign pop  = pop_avail && (!d2h_resp_valid_o || d2h_resp_ready_i);

  always_comb begin
    push_data        = '0;
    push_data.opcode = instr_i.opcode;
    push_data.dst0   = instr_i.dst0;
    push_data.seq    = seq_cnt;
    push_data.status = RESP_OK;
  end

  assign exp_addr   = {get_bank_id(cmp_dst0), get_waddr(cmp_dst0)};
  assign cmp_status = (wb_addr_i == exp_addr) ? RESP_OK
                                              : RESP_ADDR_MISMATCH;

  assign idle_o = (trk_cnt_o == '0) && !d2h_resp_valid_o;

  vpu_resp_track_buf #(
    .TRK_DEPTH     (TRK_DEPTH),
    .TRK_DEPTH_LG2 (TRK_DEPTH_LG2)
  ) u_trk (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .cmp        (cmp),
    .cmp_status (cmp_status),
    .cmp_avail  (cmp_avail),
    .cmp_dst0   (cmp_dst0),
    .pop        (pop),
    .pop_avail  (pop_avail),
    .pop_data   (pop_data),
    .full       (trk_full_o),
    .cnt        (trk_cnt_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt <= '0;
    end else if (push) begin
      seq_cnt <= seq_cnt + 1'b1;
    end
  end

  // Payload holds across stalls; only valid drops after a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d2h_resp_valid_o <= 1'b0;
      d2h_resp_o       <= '0;
    end else if (pop) begin
      d2h_resp_valid_o <= 1'b1;
      d2h_resp_o       <= pop_data;
    end else if (d2h_resp_ready_i) begin
      d2h_resp_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_o  <= 1'b0;
      err_underflow_o <= 1'b0;
    end else begin
      if (instr_accept_i && trk_full_o) err_overflow_o  <= 1'b1;
      if (wb_done_i && !cmp_avail)      err_underflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vpu_d2h_resp_ctrl.sv
// Randomized plus directed bench for vpu_d2h_resp_ctrl against a
// queue-based reference of in-order instruction completion.
module tb_vpu_d2h_resp_ctrl;
  import vpu_d2h_resp_ctrl_pkg::*;

  localparam logic [7:0] OP_FADD = 8'h01;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               instr_accept_i = 1'b0;
  vpu_h2d_req_instr_t instr_i = '0;
  logic               wb_done_i = 1'b0;
  logic [11:0]        wb_addr_i = '0;
  logic               d2h_resp_valid_o;
  logic               d2h_resp_ready_i = 1'b0;
  vpu_d2h_resp_t      d2h_resp_o;
  logic               trk_full_o;
  logic [4:0]         trk_cnt_o;
  logic               idle_o;
  logic               err_overflow_o;
  logic               err_underflow_o;

  vpu_d2h_resp_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_accept_i   (instr_accept_i),
    .instr_i          (instr_i),
    .wb_done_i        (wb_done_i),
    .wb_addr_i        (wb_addr_i),
    .d2h_resp_valid_o (d2h_resp_valid_o),
    .d2h_resp_ready_i (d2h_resp_ready_i),
    .d2h_resp_o       (d2h_resp_o),
    .trk_full_o       (trk_full_o),
    .trk_cnt_o        (trk_cnt_o),
    .idle_o           (idle_o),
    .err_overflow_o   (err_overflow_o),
    .err_underflow_o  (err_underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] dst;
    logic [3:0]  seq;
  } pend_t;

  pend_t       pend_q[$];
  logic [45:0] exp_q[$];
  logic [3:0]  seq_m = '0;
  int          checks = 0;
  int          failures = 0;
  int          n_resp = 0;
  logic [45:0] held = '0;
  bit          stall = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] good_addr(input logic [31:0] dst);
    return dst[17:6];
  endfunction

  // Response scoreboard and stall-stability watch.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall && d2h_resp_valid_o)
        chk("resp_stable", d2h_resp_o, held);
      if (d2h_resp_valid_o && d2h_resp_ready_i) begin
        if (exp_q.size() == 0) chk("resp_unexp", exp_q.size(), 1);
        else chk("resp", d2h_resp_o, exp_q.pop_front());
        n_resp++;
      end
      stall = d2h_resp_valid_o && !d2h_resp_ready_i;
      held  = d2h_resp_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cyc(input bit acc, input logic [7:0] op,
                     input logic [31:0] dst, input bit drop,
                     input bit wb, input logic [11:0] wa);
    pend_t p;
    instr_accept_i = acc;
    instr_i.opcode = op;
    instr_i.dst0   = dst;
    instr_i.src0   = $urandom;
    instr_i.src1   = $urandom;
    instr_i.src2   = $urandom;
    wb_done_i      = wb;
    wb_addr_i      = wa;
    if (wb && pend_q.size() > 0) begin
      p = pend_q.pop_front();
      exp_q.push_back({p.op, p.dst, p.seq,
                       (wa == p.dst[17:6]) ? 2'b00 : 2'b01});
    end
    if (acc && !drop) begin
      p.op = op; p.dst = dst; p.seq = seq_m;
      pend_q.push_back(p);
      seq_m++;
    end
    tick(1);
    instr_accept_i = 1'b0;
    wb_done_i      = 1'b0;
  endtask

  task automatic acc_only(input logic [7:0] op, input logic [31:0] dst);
    cyc(1'b1, op, dst, 1'b0, 1'b0, '0);
  endtask

  task automatic wb_good();
    logic [11:0] wa;
    wa = (pend_q.size() > 0) ? good_addr(pend_q[0].dst) : 12'h0;
    cyc(1'b0, '0, '0, 1'b0, 1'b1, wa);
  endtask

  task automatic wait_drain(input int lim);
    int k = 0;
    while ((exp_q.size() != 0 || d2h_resp_valid_o) && k < lim) begin
      tick(1);
      k++;
    end
    if (k >= lim) chk("drain_timeout", k, lim - 1);
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    pend_q.delete();
    exp_q.delete();
    seq_m = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int base;
    bit seen;
    tick(3);
    chk("rst_valid", d2h_resp_valid_o, 0);
    chk("rst_resp", d2h_resp_o, 0);
    chk("rst_full", trk_full_o, 0);
    chk("rst_cnt", trk_cnt_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_errs", {err_overflow_o, err_underflow_o}, 0);
    rst_n = 1'b1;
    tick(1);

    // Single FADD, exact write-back-to-valid latency.
    d2h_resp_ready_i = 1'b0;
    acc_only(OP_FADD, 32'h0000_0440);
    tick(2);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 12'h011);
    chk("t1_valid_n1", d2h_resp_valid_o, 0);
    tick(1);
    chk("t1_valid_n2", d2h_resp_valid_o, 1);
    chk("t1_payload", d2h_resp_o, {8'h01, 32'h440, 4'h0, 2'b00});
    d2h_resp_ready_i = 1'b1;
    tick(1);
    chk("t1_drained", d2h_resp_valid_o, 0);

    // Address mismatch.
    acc_only(8'h02, 32'h0000_0040);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 12'h002);
    tick(1);
    chk("t2_valid", d2h_resp_valid_o, 1);
    chk("t2_status", d2h_resp_o.status, 2'b01);
    wait_drain(20);

    // Backpressure then streaming.
    do_reset();
    d2h_resp_ready_i = 1'b0;
    acc_only(8'h03, 32'h0000_1000);
    acc_only(8'h04, 32'h0002_2040);
    acc_only(8'h05, 32'h0003_3080);
    repeat (3) wb_good();
    tick(10);
    chk("t3_cnt_stall", trk_cnt_o, 2);
    chk("t3_valid_stall", d2h_resp_valid_o, 1);
    base = n_resp;
    d2h_resp_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_stream_valid", d2h_resp_valid_o, 1);
      chk("t3_stream_seq", d2h_resp_o.seq, i);
      tick(1);
    end
    chk("t3_end_valid", d2h_resp_valid_o, 0);
    chk("t3_nresp", n_resp - base, 3);

    // Full, overflow, drain, sequence wrap.
    do_reset();
    d2h_resp_ready_i = 1'b0;
    for (int i = 0; i < 16; i++)
      acc_only(8'(i + 16), 32'($urandom) & 32'h0003_ffc0);
    chk("t4_full", trk_full_o, 1);
    chk("t4_cnt16", trk_cnt_o, 16);
    chk("t4_ovf_pre", err_overflow_o, 0);
    cyc(1'b1, 8'hff, 32'h0000_0fc0, 1'b1, 1'b0, '0);
    chk("t4_ovf", err_overflow_o, 1);
    chk("t4_cnt_hold", trk_cnt_o, 16);
    base = n_resp;
    d2h_resp_ready_i = 1'b1;
    repeat (16) wb_good();
    wait_drain(100);
    chk("t4_nresp", n_resp - base, 16);
    chk("t4_cnt0", trk_cnt_o, 0);
    chk("t4_notfull", trk_full_o, 0);
    acc_only(8'h07, 32'h0000_0080);
    wb_good();
    tick(1);
    chk("t4_wrap_valid", d2h_resp_valid_o, 1);
    chk("t4_wrap_seq", d2h_resp_o.seq, 0);
    wait_drain(20);

    // Underflow and accept coinciding with a load.
    chk("t5_uf_pre", err_underflow_o, 0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 12'h123);
    chk("t5_uf", err_underflow_o, 1);
    acc_only(8'h08, 32'h0001_0000);
    wb_good();
    chk("t5_cnt_before", trk_cnt_o, 1);
    acc_only(8'h09, 32'h0001_0040);
    chk("t5_cnt_after", trk_cnt_o, 1);
    chk("t5_load", d2h_resp_valid_o, 1);
    wb_good();
    wait_drain(20);
    chk("t5_cnt_end", trk_cnt_o, 0);

    // Reset with responses in flight.
    d2h_resp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      acc_only(8'(i + 32), 32'(i) << 6);
    repeat (4) wb_good();
    tick(2);
    chk("t6_valid_pre", d2h_resp_valid_o, 1);
    chk("t6_cnt_pre", trk_cnt_o, 3);
    #3 rst_n = 1'b0;
    #1;
    pend_q.delete();
    exp_q.delete();
    seq_m = '0;
    chk("t6_valid", d2h_resp_valid_o, 0);
    chk("t6_resp", d2h_resp_o, 0);
    chk("t6_cnt", trk_cnt_o, 0);
    chk("t6_full", trk_full_o, 0);
    chk("t6_idle", idle_o, 1);
    chk("t6_errs", {err_overflow_o, err_underflow_o}, 0);
    tick(2);
    rst_n = 1'b1;
    d2h_resp_ready_i = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick(1);
      seen |= d2h_resp_valid_o;
    end
    chk("t6_no_stale", seen, 0);

    // Randomized traffic with legal front-end behaviour.
    for (int c = 0; c < 1500; c++) begin
      bit          a;
      bit          w;
      logic [31:0] d;
      logic [11:0] wa;
      d2h_resp_ready_i = ($urandom_range(0, 3) != 0);
      a = !trk_full_o && ($urandom_range(0, 1) == 1);
      w = (pend_q.size() > 0) && ($urandom_range(0, 2) != 0);
      d = $urandom;
      wa = 12'($urandom);
      if (w && $urandom_range(0, 1) == 1) wa = good_addr(pend_q[0].dst);
      cyc(a, 8'($urandom), d, 1'b0, w, wa);
    end
    d2h_resp_ready_i = 1'b1;
    while (pend_q.size() > 0) wb_good();
    wait_drain(200);
    chk("rnd_cnt", trk_cnt_o, 0);
    chk("rnd_idle", idle_o, 1);
    chk("rnd_ovf", err_overflow_o, 0);
    chk("rnd_uf", err_underflow_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
